// File: rtl/escape_pkg.sv
// Shared types and helpers for the escape_tx serial frame transmitter.
package escape_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  // Total clk cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_len(input int width, input int clks_per_bit,
                                   input int parity_en);
    return (2 + width + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/escape_bit_timer.sv
// Phase counter that divides clk into serial bit periods; clear holds it at phase 0.
module escape_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick,
  output logic mid_tick,
  output logic pre_tick
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] LAST_PH = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] MID_PH  = PW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0] PRE_PH  = PW'(CLKS_PER_BIT - 2);

  logic [PW-1:0] phase_q, phase_d;

  assign bit_tick = (phase_q == LAST_PH);
  assign mid_tick = (phase_q == MID_PH);
  // Marks the cycle before bit_tick so the owner can register outputs for it.
  assign pre_tick = (phase_q == PRE_PH);

  always_comb begin
    phase_d = phase_q + 1'b1;
    if (clear || bit_tick) phase_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/escape_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit; samples the leaf's returned flags mid-stop-bit.
module escape_tx
  import escape_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  input  logic             ret_o10,
  input  logic             ret_o2,
  output logic             busy,
  output logic             stat_valid,
  output logic             stat_o10,
  output logic             stat_o2
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  // With two clks per bit the sample phase is the final stop cycle itself.
  localparam bit MID_IS_LAST = (CLKS_PER_BIT / 2 == CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic [1:0]       sample_q, sample_d;
  logic [1:0]       stat_q, stat_d;
  logic             stat_valid_q, stat_valid_d;
  logic             ser_out_q, ser_out_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             bit_tick, mid_tick, pre_tick;

  escape_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == IDLE),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    sample_d     = sample_q;
    stat_d       = stat_q;
    stat_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          shreg_d   = in_data;
          par_d     = ^in_data;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        if (mid_tick) sample_d = {ret_o10, ret_o2};
        // Status registers are loaded one cycle early so they appear with the last stop cycle.
        if (pre_tick) begin
          stat_valid_d = 1'b1;
          if (!MID_IS_LAST) stat_d = mid_tick ? {ret_o10, ret_o2} : sample_q;
        end
        if (bit_tick) begin
          state_d = IDLE;
          if (MID_IS_LAST) stat_d = {ret_o10, ret_o2};
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   ser_out_d = 1'b0;
      DATA:    ser_out_d = shreg_d[0];
      PARITY:  ser_out_d = par_d;
      default: ser_out_d = 1'b1;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      sample_q     <= '0;
      stat_q       <= '0;
      stat_valid_q <= 1'b0;
      ser_out_q    <= 1'b1;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      sample_q     <= sample_d;
      stat_q       <= stat_d;
      stat_valid_q <= stat_valid_d;
      ser_out_q    <= ser_out_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign stat_valid = stat_valid_q;
  // When sampling coincides with the pulse cycle, the live flags are forwarded.
  assign stat_o10   = (MID_IS_LAST && stat_valid_q) ? ret_o10 : stat_q[1];
  assign stat_o2    = (MID_IS_LAST && stat_valid_q) ? ret_o2  : stat_q[0];

endmodule
